number_entry: RTL
=================

// Module: number_entry
// PURPOSE
//   Manual byte-serial writer for the 256-bit number register: the user sets 8 switches
//   and presses a button to write one byte; bytes fill the register LSB-first.
//   Output number uses the same byte map as the byte-reader display (byte i = bits
//   [8i+7:8i]), so a value entered here reads back identically on LEDs/7-seg.
//   Sits beside the generator in main; button inputs come from button_handler_down flags.
// PARAMETERS
//   BYTES   32   number of bytes in the register (number width = 8*BYTES)
//   INVERT  1    passed to both hex2digit_hex instances (segment polarity)
// PORTS
//   clk          in   1      system clock
//   reset        in   1      synchronous, active-high reset
//   sw           in   8      byte value to write
//   btn_flg_wr   in   1      one-cycle pulse: write sw at current index
//   btn_flg_clr  in   1      one-cycle pulse: clear register and index
//   number       out  8*BYTES assembled number
//   index        out  6      next byte slot to write, 0..BYTES
//   loaded       out  1      level: all BYTES bytes written
//   done         out  1      one-cycle pulse: the final byte was just written
//   leds         out  8      echo of the last byte written
//   digs         out  14     7-seg of index: [13:7] = hex {2'b0,index[5:4]}, [6:0] = index[3:0]
// BEHAVIOUR
//   - One clock, synchronous active-high reset; all state in one clk always block, non-blocking.
//   - Reset values: number=0, index=0, loaded=0, done=0, leds=0.
//   - States: FILLING (loaded=0) and FULL (loaded=1); loaded is a register, not decoded.
//   - FILLING, wr pulse: number[8*index +: 8] <= sw; leds <= sw; index <= index+1.
//     Registered: number, leds and index change on the edge after the cycle with the pulse.
//   - Write with index==BYTES-1: index -> BYTES, loaded -> 1, done = 1 for exactly that cycle.
//   - FULL, wr pulse: ignored; number, leds, index unchanged; no done pulse.
//   - clr pulse (any state): number=0, index=0, loaded=0, leds=0, done=0.
//   - Simultaneous clr and wr: clr wins; the byte is not written.
//   - Reset overrides clr and wr; reset mid-fill discards partial content.
//   - Other bytes are never disturbed by a write; no index wrap: it saturates at BYTES.
//   - done is 0 in every cycle except the one following the final write.
//   - digs: combinational from index; index=BYTES=32 displays "20".
//   - sw is sampled only in the cycle of the wr pulse.
// STRUCTURE
//   - Shared package/include: BYTES default 32, byte width 8, index width 6.
//   - Sub-module: hex2digit_hex, two instances (high and low digit); no new sub-module.
//   - Byte slot write: generate loop over BYTES slots, each enabled by (index==i) & wr
//     & ~loaded & ~clr, all inside the clk domain (no flag-edge clocking).
// TESTING
//   1. Reset, then wr with sw=8'hA5 -> number[7:0]=A5, rest 0, index=1, leds=A5, digs "01".
//   2. 32 writes of sw=i+1 (i=0..31) -> number[8i+7:8i]=i+1; loaded=1; done high one cycle
//      after 32nd write only; index=32, digs "20".
//   3. In FULL, wr with sw=8'hFF -> number, leds, index unchanged; done stays 0.
//   4. Write 5 bytes, pulse clr together with wr sw=8'h3C -> number=0, index=0, leds=0, loaded=0.
//   5. Write 10 bytes, assert reset one cycle -> all outputs at reset values; next wr sw=8'h11
//      lands in byte 0.
//   6. Write 8'h5A in slot 0, then 8'hC3 in slot 1 -> byte0 still 5A, byte1=C3, leds=C3.

Source files
------------

// File: rtl/number_entry_pkg.sv
// Shared sizing and state encoding for the byte-serial number entry block.
package number_entry_pkg;

    localparam int BYTES_DEFAULT = 32;
    localparam int BYTE_W        = 8;
    localparam int INDEX_W       = 6;

    // FULL is encoded as 1 so the state bit itself drives the loaded output.
    typedef enum logic {
        FILLING = 1'b0,
        FULL    = 1'b1
    } fill_state_t;

endpackage

// File: rtl/hex2digit_hex.sv
// Hex nibble to 7-segment pattern (bit 0 = segment a ... bit 6 = segment g).
module hex2digit_hex #(
    parameter bit INVERT = 1'b1
) (
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    logic [6:0] raw;

    always_comb begin
        raw = 7'h00;
        case (hex)
            4'h0: raw = 7'h3F;
            4'h1: raw = 7'h06;
            4'h2: raw = 7'h5B;
            4'h3: raw = 7'h4F;
            4'h4: raw = 7'h66;
            4'h5: raw = 7'h6D;
            4'h6: raw = 7'h7D;
            4'h7: raw = 7'h07;
            4'h8: raw = 7'h7F;
            4'h9: raw = 7'h6F;
            4'hA: raw = 7'h77;
            4'hB: raw = 7'h7C;
            4'hC: raw = 7'h39;
            4'hD: raw = 7'h5E;
            4'hE: raw = 7'h79;
            4'hF: raw = 7'h71;
            default: raw = 7'h00;
        endcase
    end

    // Common-anode displays want segments active-low.
    assign seg = INVERT ? ~raw : raw;

endmodule

// File: rtl/number_entry.sv
// Byte-serial manual writer for the wide number register: switches plus a write
// button fill the register LSB-first; a clear button empties it.
module number_entry
    import number_entry_pkg::*;
#(
    parameter int BYTES  = BYTES_DEFAULT,
    parameter bit INVERT = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [BYTE_W-1:0]         sw,
    input  logic                      btn_flg_wr,
    input  logic                      btn_flg_clr,
    output logic [BYTE_W*BYTES-1:0]   number,
    output logic [INDEX_W-1:0]        index,
    output logic                      loaded,
    output logic                      done,
    output logic [BYTE_W-1:0]         leds,
    output logic [13:0]               digs
);

    fill_state_t              state_q, state_d;
    logic [INDEX_W-1:0]       index_q, index_d;
    logic                     done_q, done_d;
    logic [BYTE_W-1:0]        leds_q;
    logic [BYTE_W*BYTES-1:0]  number_q;
    logic [BYTES-1:0]         slot_en;
    logic                     wr_ok;

    assign wr_ok = btn_flg_wr & (state_q == FILLING) & ~btn_flg_clr;

    for (genvar i = 0; i < BYTES; i++) begin : g_slot
        assign slot_en[i] = (index_q == INDEX_W'(i)) & btn_flg_wr & ~state_q & ~btn_flg_clr;
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        done_d  = 1'b0;
        if (btn_flg_clr) begin
            state_d = FILLING;
            index_d = '0;
        end else if (wr_ok) begin
            index_d = index_q + INDEX_W'(1);
            if (index_q == INDEX_W'(BYTES - 1)) begin
                state_d = FULL;
                done_d  = 1'b1;
            end
        end
    end

    // Clear takes priority over a coincident write, so the byte is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FILLING;
            index_q  <= '0;
            done_q   <= 1'b0;
            leds_q   <= '0;
            number_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            done_q  <= done_d;
            if (btn_flg_clr) begin
                leds_q   <= '0;
                number_q <= '0;
            end else begin
                if (wr_ok) begin
                    leds_q <= sw;
                end
                for (int i = 0; i < BYTES; i++) begin
                    if (slot_en[i]) begin
                        number_q[BYTE_W*i +: BYTE_W] <= sw;
                    end
                end
            end
        end
    end

    assign number = number_q;
    assign index  = index_q;
    assign loaded = state_q;
    assign done   = done_q;
    assign leds   = leds_q;

    hex2digit_hex #(.INVERT(INVERT)) u_dig_hi (
        .hex ({2'b00, index_q[5:4]}),
        .seg (digs[13:7])
    );

    hex2digit_hex #(.INVERT(INVERT)) u_dig_lo (
        .hex (index_q[3:0]),
        .seg (digs[6:0])
    );

endmodule
